multicycle_control_unit: RTL and testbench



---
 rtl/multicycle_control_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// multicycle_control_unit: FSM stepping RV64 subset fetch/decode/exec/mem/wb
// Revision: 1.0
// ============================================================================
module multicycle_control_unit #(
   parameter int unsigned EXT_ALU     = 1,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned ALUCTRL_W   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          instruction,
   input  logic                 imem_ready,
   input  logic                 dmem_ready,
   input  logic                 alu_zero,
   input  logic                 alu_lt,
   output logic                 imem_req,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 pc_src,
   output logic                 regWrite,
   output logic                 memWrite,
   output logic                 memRead,
   output logic                 aluSrc,
   output logic                 memToReg,
   output logic [ALUCTRL_W-1:0] aluControl,
   output logic                 retire,
   output logic                 illegal,
   output logic                 bus_error,
   output logic [2:0]           state
);
   localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
                          S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP    = 3'd7;
   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                          OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011;
   localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                          ALU_XOR = 4'b0011, ALU_SLL = 4'b0100, ALU_SRL = 4'b0101,
                          ALU_SUB = 4'b0110, ALU_SRA = 4'b0111, ALU_SLT = 4'b1000;
   localparam bit         EXT_EN    = (EXT_ALU != 0);
   localparam bit         WDOG_EN   = (MEM_TIMEOUT != 0);
   localparam logic [7:0] WDOG_LAST = WDOG_EN ? 8'(MEM_TIMEOUT - 1) : 8'd0;

   logic [6:0] opcode, funct7;
   logic [5:0] funct6;
   logic [2:0] funct3;
   logic       unused_fields;
   assign opcode        = instruction[6:0];
   assign funct3        = instruction[14:12];
   assign funct7        = instruction[31:25];
   assign funct6        = instruction[31:26];
   assign unused_fields = ^{instruction[24:15], instruction[11:7]};

   logic       is_i, is_load, is_store, is_branch, legal, taken;
   logic [3:0] alu_op;

   always_comb begin
      is_i      = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      legal     = 1'b0;
      taken     = 1'b0;
      alu_op    = ALU_ADD;
      case (opcode)
         OP_R: begin
            case ({funct7, funct3})
               {7'b0000000, 3'b000}: begin legal = 1'b1;   alu_op = ALU_ADD; end
               {7'b0100000, 3'b000}: begin legal = 1'b1;   alu_op = ALU_SUB; end
               {7'b0000000, 3'b111}: begin legal = 1'b1;   alu_op = ALU_AND; end
               {7'b0000000, 3'b110}: begin legal = 1'b1;   alu_op = ALU_OR;  end
               {7'b0000000, 3'b100}: begin legal = 1'b1;   alu_op = ALU_XOR; end
               {7'b0000000, 3'b001}: begin legal = 1'b1;   alu_op = ALU_SLL; end
               {7'b0000000, 3'b101}: begin legal = 1'b1;   alu_op = ALU_SRL; end
               {7'b0100000, 3'b101}: begin legal = EXT_EN; alu_op = ALU_SRA; end
               {7'b0000000, 3'b010}: begin legal = EXT_EN; alu_op = ALU_SLT; end
               default: ;
            endcase
         end
         OP_I: begin
            is_i = 1'b1;
            case (funct3)
               3'b000: begin legal = 1'b1; alu_op = ALU_ADD; end
               3'b111: begin legal = 1'b1; alu_op = ALU_AND; end
               3'b110: begin legal = 1'b1; alu_op = ALU_OR;  end
               3'b100: begin legal = 1'b1; alu_op = ALU_XOR; end
               3'b001: begin legal = (funct6 == 6'b000000); alu_op = ALU_SLL; end
               3'b101: begin
                  // RV64 shamt is 6 bits, so only instruction[31:26] selects the shift kind
                  if (funct6 == 6'b000000) begin
                     legal  = 1'b1;
                     alu_op = ALU_SRL;
                  end else if (funct6 == 6'b010000) begin
                     legal  = EXT_EN;
                     alu_op = ALU_SRA;
                  end
               end
               3'b010: begin legal = EXT_EN; alu_op = ALU_SLT; end
               default: ;
            endcase
         end
         OP_LOAD: begin
            is_load = 1'b1;
            legal   = (funct3 == 3'b011);
         end
         OP_STORE: begin
            is_store = 1'b1;
            legal    = (funct3 == 3'b011);
         end
         OP_BRANCH: begin
            is_branch = 1'b1;
            alu_op    = ALU_SUB;
            case (funct3)
               3'b000: begin legal = 1'b1; taken = alu_zero;  end
               3'b001: begin legal = 1'b1; taken = !alu_zero; end
               3'b100: begin legal = 1'b1; taken = alu_lt;    end
               3'b101: begin legal = 1'b1; taken = !alu_lt;   end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   logic [2:0] state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       illegal_q, illegal_d, bus_error_q, bus_error_d;
   logic       wdog_expired;
   assign wdog_expired = WDOG_EN && (wait_cnt_q == WDOG_LAST);

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = 8'd0;
      illegal_d   = illegal_q;
      bus_error_d = bus_error_q;
      imem_req    = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      regWrite    = 1'b0;
      memWrite    = 1'b0;
      memRead     = 1'b0;
      aluSrc      = 1'b0;
      memToReg    = 1'b0;
      retire      = 1'b0;
      aluControl  = '0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end else if (wdog_expired) begin
               state_d     = S_TRAP;
               bus_error_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_DECODE: begin
            if (legal) begin
               state_d = S_EXECUTE;
            end else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end
         S_EXECUTE: begin
            aluControl = ALUCTRL_W'(alu_op);
            aluSrc     = is_i | is_load | is_store;
            if (is_branch) begin
               pc_write = 1'b1;
               pc_src   = taken;
               retire   = 1'b1;
               state_d  = S_FETCH;
            end else if (is_load | is_store) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            aluControl = ALUCTRL_W'(alu_op);
            memRead    = is_load;
            memWrite   = is_store;
            if (dmem_ready) begin
               if (is_load) begin
                  state_d = S_WB;
               end else begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  state_d  = S_FETCH;
               end
            end else if (wdog_expired) begin
               state_d     = S_TRAP;
               bus_error_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_WB: begin
            aluControl = ALUCTRL_W'(alu_op);
            regWrite   = 1'b1;
            pc_write   = 1'b1;
            retire     = 1'b1;
            memToReg   = is_load;
            state_d    = S_FETCH;
         end
         S_TRAP: ;
         default: state_d = S_FETCH;
      endcase
      // outputs are quiet for the whole reset window, not just after the next edge
      if (reset) begin
         imem_req   = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         pc_src     = 1'b0;
         regWrite   = 1'b0;
         memWrite   = 1'b0;
         memRead    = 1'b0;
         aluSrc     = 1'b0;
         memToReg   = 1'b0;
         retire     = 1'b0;
         aluControl = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_FETCH;
         wait_cnt_q  <= 8'd0;
         illegal_q   <= 1'b0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         illegal_q   <= illegal_d;
         bus_error_q <= bus_error_d;
      end
   end

   assign state     = state_q;
   assign illegal   = illegal_q;
   assign bus_error = bus_error_q;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// tb_multicycle_control_unit: directed instructions checked cycle-by-cycle against
// a transaction-level expectation model, plus literal latency/encoding pins.
module tb_multicycle_control_unit;
   localparam int TMO = 4;
   localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_BR = 5;

   // R-type operation table: funct7, funct3, aluControl, needs extended ALU
   localparam logic [6:0] R_F7  [9] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00};
   localparam logic [2:0] R_F3  [9] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd5, 3'd5, 3'd2};
   localparam logic [3:0] R_OP  [9] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
   localparam bit         R_EXT [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   typedef struct packed {
      logic       imem_req, ir_write, pc_write, pc_src, reg_write, mem_write;
      logic       mem_read, alu_src, mem_to_reg, retire, illegal, bus_error;
      logic [3:0] alu;
      logic [2:0] state;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instruction = 32'd0;
   logic        imem_ready = 1'b0, dmem_ready = 1'b0, alu_zero = 1'b0, alu_lt = 1'b0;

   // index 1: EXT_ALU=1 instance, index 0: EXT_ALU=0 instance
   logic [1:0] o_imem_req, o_ir_write, o_pc_write, o_pc_src, o_reg_write, o_mem_write;
   logic [1:0] o_mem_read, o_alu_src, o_mem_to_reg, o_retire, o_illegal, o_bus_error;
   logic [3:0] o_alu   [2];
   logic [2:0] o_state [2];

   int    errors = 0, checks = 0;
   int    sel = 1, cyc = 0, ret_cyc = -1, rd_cnt = 0, exec_alu = -1, pcsrc_seen = -1;
   bit    active = 1'b0;
   string tname = "none";
   exp_t  exp_q[$];
   exp_t  got, want;

   always #5 clk = ~clk;

   multicycle_control_unit #(.EXT_ALU(1), .MEM_TIMEOUT(TMO), .ALUCTRL_W(4)) u_ext (
      .clk(clk), .reset(reset), .instruction(instruction), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .alu_zero(alu_zero), .alu_lt(alu_lt),
      .imem_req(o_imem_req[1]), .ir_write(o_ir_write[1]), .pc_write(o_pc_write[1]),
      .pc_src(o_pc_src[1]), .regWrite(o_reg_write[1]), .memWrite(o_mem_write[1]),
      .memRead(o_mem_read[1]), .aluSrc(o_alu_src[1]), .memToReg(o_mem_to_reg[1]),
      .aluControl(o_alu[1]), .retire(o_retire[1]), .illegal(o_illegal[1]),
      .bus_error(o_bus_error[1]), .state(o_state[1]));

   multicycle_control_unit #(.EXT_ALU(0), .MEM_TIMEOUT(TMO), .ALUCTRL_W(4)) u_base (
      .clk(clk), .reset(reset), .instruction(instruction), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .alu_zero(alu_zero), .alu_lt(alu_lt),
      .imem_req(o_imem_req[0]), .ir_write(o_ir_write[0]), .pc_write(o_pc_write[0]),
      .pc_src(o_pc_src[0]), .regWrite(o_reg_write[0]), .memWrite(o_mem_write[0]),
      .memRead(o_mem_read[0]), .aluSrc(o_alu_src[0]), .memToReg(o_mem_to_reg[0]),
      .aluControl(o_alu[0]), .retire(o_retire[0]), .illegal(o_illegal[0]),
      .bus_error(o_bus_error[0]), .state(o_state[0]));

   function automatic exp_t observe(input int s);
      exp_t o;
      o.imem_req   = o_imem_req[s];   o.ir_write  = o_ir_write[s];
      o.pc_write   = o_pc_write[s];   o.pc_src    = o_pc_src[s];
      o.reg_write  = o_reg_write[s];  o.mem_write = o_mem_write[s];
      o.mem_read   = o_mem_read[s];   o.alu_src   = o_alu_src[s];
      o.mem_to_reg = o_mem_to_reg[s]; o.retire    = o_retire[s];
      o.illegal    = o_illegal[s];    o.bus_error = o_bus_error[s];
      o.alu        = o_alu[s];        o.state     = o_state[s];
      return o;
   endfunction

   function automatic exp_t rec(input logic [2:0] st);
      exp_t r;
      r = '0;
      r.state = st;
      return r;
   endfunction

   function automatic void decode(input logic [31:0] ins, input bit ext,
                                  output int kind, output logic [3:0] alu);
      logic [6:0] op, f7;
      logic [2:0] f3;
      logic [5:0] f6;
      op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; f6 = ins[31:26];
      kind = K_ILL;
      alu  = 4'd0;
      if (op == 7'h33) begin
         for (int k = 0; k < 9; k++)
            if (f7 == R_F7[k] && f3 == R_F3[k] && (ext || !R_EXT[k])) begin
               kind = K_R; alu = R_OP[k];
            end
      end else if (op == 7'h13) begin
         // immediate forms are the funct7=0 R ops; shifts need a zero upper field
         for (int k = 0; k < 9; k++)
            if (R_F7[k] == 7'h00 && f3 == R_F3[k] && (ext || !R_EXT[k]) &&
                (!(f3 == 3'd1 || f3 == 3'd5) || f6 == 6'd0)) begin
               kind = K_I; alu = R_OP[k];
            end
         if (ext && f3 == 3'd5 && f6 == 6'b010000) begin kind = K_I; alu = 4'd7; end
      end else if (op == 7'h03 && f3 == 3'd3) begin
         kind = K_LD; alu = 4'd2;
      end else if (op == 7'h23 && f3 == 3'd3) begin
         kind = K_ST; alu = 4'd2;
      end else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5)) begin
         kind = K_BR; alu = 4'd6;
      end
   endfunction

   task automatic push_trap(input logic ill, input logic be);
      exp_t r;
      r = rec(3'd7);
      r.illegal = ill;
      r.bus_error = be;
      repeat (3) exp_q.push_back(r);
   endtask

   task automatic push_fetch();
      exp_t r;
      r = rec(3'd0);
      r.imem_req = 1'b1;
      exp_q.push_back(r);
   endtask

   // Expected per-cycle trace of one instruction from the first FETCH cycle
   task automatic model(input logic [31:0] ins, input bit ext, input int iw, input int dw,
                        input logic z, input logic l);
      int         kind;
      logic [3:0] alu;
      logic [2:0] f3;
      exp_t       r;
      exp_q.delete();
      decode(ins, ext, kind, alu);
      f3 = ins[14:12];
      r = rec(3'd0);
      r.imem_req = 1'b1;
      if (iw >= TMO) begin
         repeat (TMO) exp_q.push_back(r);
         push_trap(1'b0, 1'b1);
         return;
      end
      repeat (iw) exp_q.push_back(r);
      r.ir_write = 1'b1;
      exp_q.push_back(r);
      exp_q.push_back(rec(3'd1));
      if (kind == K_ILL) begin
         push_trap(1'b1, 1'b0);
         return;
      end
      r = rec(3'd2);
      r.alu = alu;
      r.alu_src = (kind == K_I || kind == K_LD || kind == K_ST);
      if (kind == K_BR) begin
         r.pc_write = 1'b1;
         r.retire   = 1'b1;
         r.pc_src   = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? l : !l;
         exp_q.push_back(r);
         push_fetch();
         return;
      end
      exp_q.push_back(r);
      if (kind == K_LD || kind == K_ST) begin
         r = rec(3'd3);
         r.alu = alu;
         r.mem_read  = (kind == K_LD);
         r.mem_write = (kind == K_ST);
         if (dw >= TMO) begin
            repeat (TMO) exp_q.push_back(r);
            push_trap(1'b0, 1'b1);
            return;
         end
         repeat (dw) exp_q.push_back(r);
         if (kind == K_ST) begin
            r.pc_write = 1'b1;
            r.retire   = 1'b1;
            exp_q.push_back(r);
            push_fetch();
            return;
         end
         exp_q.push_back(r);
      end
      r = rec(3'd4);
      r.alu = alu;
      r.reg_write = 1'b1;
      r.pc_write  = 1'b1;
      r.retire    = 1'b1;
      r.mem_to_reg = (kind == K_LD);
      exp_q.push_back(r);
      push_fetch();
   endtask

   always @(negedge clk) begin
      if (active) begin
         got = observe(sel);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s cycle %0d: trace longer than expected, got %h", tname, cyc, got);
         end else begin
            want = exp_q.pop_front();
            if (got !== want)
               begin
                  errors++;
                  $display("FAIL %s cycle %0d: got %h want %h", tname, cyc, got, want);
               end
         end
         if (got.retire && ret_cyc < 0) ret_cyc = cyc;
         if (got.mem_read) rd_cnt++;
         if (got.pc_write) pcsrc_seen = int'(got.pc_src);
         if (got.state == 3'd2) exec_alu = int'(got.alu);
         cyc++;
      end
   end

   task automatic chk(input string nm, input int g, input int w);
      checks++;
      if (g != w) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, g, w);
      end
   endtask

   task automatic run(input string nm, input int s, input logic [31:0] ins, input int iw,
                      input int dw, input logic z, input logic l);
      int n;
      tname = nm;
      sel = s;
      @(posedge clk); #1;
      reset = 1'b1; instruction = ins; alu_zero = z; alu_lt = l;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      @(negedge clk);
      checks++;
      got = observe(sel);
      if (got !== rec(3'd0)) begin
         errors++;
         $display("FAIL %s reset_state: got %h want %h", nm, got, rec(3'd0));
      end
      model(ins, s == 1, iw, dw, z, l);
      n = exp_q.size();
      @(posedge clk); #1;
      reset = 1'b0;
      cyc = 0; ret_cyc = -1; rd_cnt = 0; exec_alu = -1; pcsrc_seen = -1;
      active = 1'b1;
      for (int c = 0; c < n; c++) begin
         imem_ready = (c == iw);
         dmem_ready = (c == iw + 3 + dw);
         @(posedge clk); #1;
      end
      active = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      run("sub", 1, 32'h40628233, 0, 0, 1'b0, 1'b0);
      chk("sub_retire_cycle", ret_cyc, 3);
      chk("sub_alu", exec_alu, 6);
      run("ld_wait", 1, 32'h00003203, 0, 3, 1'b0, 1'b0);
      chk("ld_retire_cycle", ret_cyc, 7);
      chk("ld_memread_cycles", rd_cnt, 4);
      run("bne_nz", 1, 32'h00209463, 0, 0, 1'b0, 1'b0);
      chk("bne_nz_pc_src", pcsrc_seen, 1);
      chk("bne_retire_cycle", ret_cyc, 2);
      run("bne_z", 1, 32'h00209463, 0, 0, 1'b1, 1'b0);
      chk("bne_z_pc_src", pcsrc_seen, 0);
      run("blt_lt", 1, 32'h0020C463, 1, 0, 1'b0, 1'b1);
      chk("blt_lt_pc_src", pcsrc_seen, 1);
      run("blt_ge", 1, 32'h0020C463, 0, 0, 1'b0, 1'b0);
      chk("blt_ge_pc_src", pcsrc_seen, 0);
      run("bge_ge", 1, 32'h0020D463, 0, 0, 1'b1, 1'b0);
      chk("bge_ge_pc_src", pcsrc_seen, 1);
      run("beq_z", 1, 32'h00208463, 0, 0, 1'b1, 1'b1);
      chk("beq_z_pc_src", pcsrc_seen, 1);
      run("ill_opcode", 1, 32'h0000007F, 0, 0, 1'b0, 1'b0);
      chk("ill_opcode_no_retire", ret_cyc, -1);
      chk("ill_opcode_state", int'(o_state[1]), 7);
      chk("ill_opcode_flag", int'(o_illegal[1]), 1);
      run("ill_funct7", 1, 32'h02208033, 0, 0, 1'b0, 1'b0);
      chk("ill_funct7_flag", int'(o_illegal[1]), 1);
      run("wdog_fetch", 1, 32'h00108093, 4, 0, 1'b0, 1'b0);
      chk("wdog_fetch_bus_error", int'(o_bus_error[1]), 1);
      chk("wdog_fetch_state", int'(o_state[1]), 7);
      run("wdog_edge", 1, 32'h00108093, 3, 0, 1'b0, 1'b0);
      chk("wdog_edge_retire_cycle", ret_cyc, 6);
      chk("wdog_edge_bus_error", int'(o_bus_error[1]), 0);
      run("sra_base", 0, 32'h4020d1b3, 0, 0, 1'b0, 1'b0);
      chk("sra_base_illegal", int'(o_illegal[0]), 1);
      run("sra_ext", 1, 32'h4020d1b3, 0, 0, 1'b0, 1'b0);
      chk("sra_ext_alu", exec_alu, 7);
      run("slt_ext", 1, 32'h0020A033, 0, 0, 1'b0, 1'b0);
      chk("slt_ext_alu", exec_alu, 8);
      run("slti_base", 0, 32'h0010A093, 0, 0, 1'b0, 1'b0);
      run("srai_ext", 1, 32'h4010D093, 2, 0, 1'b0, 1'b0);
      chk("srai_ext_alu", exec_alu, 7);
      run("slli_bad_f6", 1, 32'h04109093, 0, 0, 1'b0, 1'b0);
      run("lw_illegal", 1, 32'h00002203, 0, 0, 1'b0, 1'b0);
      run("sd_wait", 1, 32'h00113023, 1, 1, 1'b0, 1'b0);
      chk("sd_retire_cycle", ret_cyc, 5);
      run("sd_wdog", 1, 32'h00113023, 0, 4, 1'b0, 1'b0);
      chk("sd_wdog_bus_error", int'(o_bus_error[1]), 1);
      run("and_wait", 1, 32'h0020F033, 2, 0, 1'b0, 1'b0);
      chk("and_alu", exec_alu, 0);

      // asynchronous reset while a store sits in MEM
      tname = "st_reset_mid_mem";
      sel = 1;
      @(posedge clk); #1;
      reset = 1'b1; instruction = 32'h00113023; imem_ready = 1'b0; dmem_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         imem_ready = (c == 0);
         @(posedge clk); #1;
      end
      imem_ready = 1'b0;
      #2;
      chk("st_mid_mem_memwrite", int'(o_mem_write[1]), 1);
      chk("st_mid_mem_state", int'(o_state[1]), 3);
      reset = 1'b1;
      #1;
      chk("st_reset_memwrite", int'(o_mem_write[1]), 0);
      chk("st_reset_state", int'(o_state[1]), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      #2;
      chk("st_after_reset_state", int'(o_state[1]), 0);
      chk("st_after_reset_imem_req", int'(o_imem_req[1]), 1);
      chk("st_after_reset_memwrite", int'(o_mem_write[1]), 0);
      @(posedge clk); #1;
      chk("st_after_reset_regwrite", int'(o_reg_write[1]), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
